// File: rtl/ecc_157_pkg.sv
// ecc_157_pkg: shared constants, H-matrix and parity function for the 157-bit SECDED code.
// Used by both the write-side encoder and the read-side check/correct path.
package ecc_157_pkg;

    localparam int DATA_WIDTH   = 157;
    localparam int PARITY_WIDTH = 9;
    localparam int HAM_WIDTH    = PARITY_WIDTH - 1;

    typedef logic [DATA_WIDTH-1:0]   data_t;
    typedef logic [PARITY_WIDTH-1:0] parity_t;
    typedef logic [HAM_WIDTH-1:0]    col_t;

    typedef struct packed {
        data_t   data;
        parity_t parity;
        logic    fault;
    } beat_t;

    // Data bit k sits at the k-th non-power-of-two codeword position; its column is that position.
    function automatic logic [DATA_WIDTH*HAM_WIDTH-1:0] build_h_cols();
        logic [DATA_WIDTH*HAM_WIDTH-1:0] c;
        int k;
        c = '0;
        k = 0;
        for (int p = 3; p < 2 ** HAM_WIDTH; p++) begin
            if ((p & (p - 1)) != 0 && k < DATA_WIDTH) begin
                c[k*HAM_WIDTH +: HAM_WIDTH] = p[HAM_WIDTH-1:0];
                k++;
            end
        end
        return c;
    endfunction

    localparam logic [DATA_WIDTH*HAM_WIDTH-1:0] H_COLS = build_h_cols();

    function automatic col_t h_col(input int i);
        return H_COLS[i*HAM_WIDTH +: HAM_WIDTH];
    endfunction

    function automatic parity_t ecc_157_parity(input data_t data);
        col_t syn;
        syn = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (data[i]) syn = syn ^ h_col(i);
        end
        return {^data ^ ^syn, syn};
    endfunction

endpackage

// File: rtl/ecc_157_enc.sv
// ecc_157_enc: combinational SECDED parity generator for one 157-bit payload.
module ecc_157_enc
    import ecc_157_pkg::*;
(
    input  logic [DATA_WIDTH-1:0]   data,
    output logic [PARITY_WIDTH-1:0] parity
);

    assign parity = ecc_157_parity(data);

endmodule

// File: rtl/ecc_157_wr_enc.sv
// ecc_157_wr_enc: write-side SECDED encoder with redundant encoders, fault status,
// error injection and a 1-deep valid/ready output register.
module ecc_157_wr_enc
    import ecc_157_pkg::*;
#(
    parameter int CNT_WIDTH = 8,
    parameter int INJ_BIT0  = 0,
    parameter int INJ_BIT1  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic                    bypass,
    input  logic                    ecc_fault_detc_en,
    input  logic                    inj_sbit,
    input  logic                    inj_dbit,
    input  logic                    fault_clr,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic [PARITY_WIDTH-1:0] out_parity,
    output logic                    out_ecc_fault,
    output logic                    fault_sticky,
    output logic [CNT_WIDTH-1:0]    fault_cnt
);

    parity_t p0;
    parity_t p1;
    data_t   inj_mask;
    beat_t   beat_q;
    logic    accept;
    logic    fault;
    logic    fault_beat;

    ecc_157_enc u0 (.data(in_data), .parity(p0));
    ecc_157_enc u1 (.data(in_data), .parity(p1));

    assign in_ready   = ~out_valid | out_ready;
    assign accept     = in_valid & in_ready;
    assign fault      = (p0 != p1) & ecc_fault_detc_en & ~bypass;
    assign fault_beat = accept & fault;

    // Injection flips payload only, so stored parity still describes the clean data.
    always_comb begin
        inj_mask           = '0;
        inj_mask[INJ_BIT0] = inj_sbit | inj_dbit;
        inj_mask[INJ_BIT1] = inj_dbit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            beat_q    <= '0;
        end else if (accept) begin
            out_valid     <= 1'b1;
            beat_q.data   <= in_data ^ inj_mask;
            beat_q.parity <= bypass ? '0 : p0;
            beat_q.fault  <= fault;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign out_data      = beat_q.data;
    assign out_parity    = beat_q.parity;
    assign out_ecc_fault = beat_q.fault;

    // A clear coinciding with a fault beat restarts the count at one rather than zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_sticky <= 1'b0;
            fault_cnt    <= '0;
        end else if (fault_clr) begin
            fault_sticky <= fault_beat;
            fault_cnt    <= {{(CNT_WIDTH-1){1'b0}}, fault_beat};
        end else if (fault_beat) begin
            fault_sticky <= 1'b1;
            if (~&fault_cnt) fault_cnt <= fault_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_ecc_157_wr_enc.sv
// tb_ecc_157_wr_enc: randomized self-checking bench for the write-side SECDED encoder.
module tb_ecc_157_wr_enc;

    localparam int DW = 157;
    localparam int PW = 9;
    localparam int CW = 8;
    localparam int B0 = 0;
    localparam int B1 = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          bypass = 1'b0;
    logic          en = 1'b0;
    logic          inj_sbit = 1'b0;
    logic          inj_dbit = 1'b0;
    logic          fault_clr = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [PW-1:0] out_parity;
    logic          out_ecc_fault;
    logic          fault_sticky;
    logic [CW-1:0] fault_cnt;

    int passed = 0;
    int total  = 0;

    ecc_157_wr_enc #(.CNT_WIDTH(CW), .INJ_BIT0(B0), .INJ_BIT1(B1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .bypass(bypass), .ecc_fault_detc_en(en),
        .inj_sbit(inj_sbit), .inj_dbit(inj_dbit), .fault_clr(fault_clr),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_parity(out_parity), .out_ecc_fault(out_ecc_fault),
        .fault_sticky(fault_sticky), .fault_cnt(fault_cnt)
    );

    always #5 clk = ~clk;

    // Reference: lay the payload into a Hamming codeword (check bits at powers of two),
    // syndrome = XOR of positions holding a 1, overall bit = even parity of the codeword.
    function automatic logic [PW-1:0] ref_parity(input logic [DW-1:0] d);
        logic [255:0] code;
        logic [7:0]   syn;
        int           k;
        code = '0;
        k = 0;
        for (int pos = 1; pos < 256; pos++) begin
            if (pos != 1 && pos != 2 && pos != 4 && pos != 8 && pos != 16 &&
                pos != 32 && pos != 64 && pos != 128 && k < DW) begin
                code[pos] = d[k];
                k++;
            end
        end
        syn = '0;
        for (int pos = 1; pos < 256; pos++) if (code[pos]) syn = syn ^ 8'(pos);
        return {(^code) ^ (^syn), syn};
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [159:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return t[DW-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        #1;
        total++;
        if ({out_valid, out_data, out_parity, out_ecc_fault, fault_sticky, fault_cnt} !== '0)
            $display("FAIL reset_outputs: got valid=%b par=%h flt=%b sticky=%b cnt=%0d, need all 0",
                     out_valid, out_parity, out_ecc_fault, fault_sticky, fault_cnt);
        else passed++;
        tick();
        rst_n = 1'b1;
        tick();
        total++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b need 1", in_ready);
        else passed++;
    endtask

    task automatic test_first_beat();
        in_valid  = 1'b1;
        in_data   = '0;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || out_data !== '0 || out_parity !== 9'h000 || out_ecc_fault !== 1'b0)
            $display("FAIL first_beat: got valid=%b data_nz=%b par=%h flt=%b, need 1/0/000/0",
                     out_valid, |out_data, out_parity, out_ecc_fault);
        else passed++;
        drain();
    endtask

    task automatic test_stream();
        logic [DW-1:0] d;
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            d = rand_data();
            in_valid = 1'b1;
            in_data  = d;
            #1;
            total++;
            if (in_ready !== 1'b1) $display("FAIL stream_ready[%0d]: got %b need 1", i, in_ready);
            else passed++;
            tick();
            total++;
            if (out_valid !== 1'b1 || out_data !== d || out_parity !== ref_parity(d))
                $display("FAIL stream_beat[%0d]: got valid=%b par=%h data_ok=%b, need 1 par=%h",
                         i, out_valid, out_parity, out_data === d, ref_parity(d));
            else passed++;
        end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] src[8];
        logic [DW-1:0] q[$];
        logic          exp_ready;
        int            sent = 0;
        int            got = 0;
        for (int i = 0; i < 8; i++) src[i] = rand_data();
        for (int cyc = 0; cyc < 24; cyc++) begin
            out_ready = !(cyc < 5);
            in_valid  = sent < 8;
            in_data   = sent < 8 ? src[sent] : '0;
            #1;
            exp_ready = q.size() == 0 || out_ready;
            total++;
            if (in_ready !== exp_ready)
                $display("FAIL bp_in_ready[%0d]: got %b need %b", cyc, in_ready, exp_ready);
            else passed++;
            total++;
            if (q.size() != 0) begin
                if (out_valid !== 1'b1 || out_data !== q[0] || out_parity !== ref_parity(q[0]))
                    $display("FAIL bp_out[%0d]: got valid=%b par=%h data_ok=%b, need beat %0d par=%h",
                             cyc, out_valid, out_parity, out_data === q[0], got, ref_parity(q[0]));
                else passed++;
                if (out_ready) begin
                    void'(q.pop_front());
                    got++;
                end
            end else begin
                if (out_valid !== 1'b0) $display("FAIL bp_idle[%0d]: got valid=%b need 0", cyc, out_valid);
                else passed++;
            end
            if (in_valid && exp_ready) begin
                q.push_back(in_data);
                sent++;
            end
            @(posedge clk);
            #0;
        end
        total++;
        if (got != 8 || q.size() != 0)
            $display("FAIL bp_count: got %0d beats (%0d left), need 8 (0 left)", got, q.size());
        else passed++;
        #1;
        drain();
    endtask

    task automatic send_zero(input int n);
        in_data   = '0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < n; i++) tick();
        in_valid = 1'b0;
    endtask

    task automatic test_fault();
        force dut.p1 = 9'h008;
        en = 1'b1;
        in_data = '0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            tick();
            total++;
            if (out_ecc_fault !== 1'b1 || out_parity !== 9'h000)
                $display("FAIL fault_beat[%0d]: got flt=%b par=%h need 1/000", i, out_ecc_fault, out_parity);
            else passed++;
        end
        in_valid = 1'b0;
        tick();
        tick();
        total++;
        if (fault_sticky !== 1'b1 || fault_cnt !== 8'd3)
            $display("FAIL fault_status: got sticky=%b cnt=%0d need 1/3", fault_sticky, fault_cnt);
        else passed++;
        en = 1'b0;
        send_zero(3);
        total++;
        if (out_ecc_fault !== 1'b0 || fault_cnt !== 8'd3)
            $display("FAIL fault_disabled: got flt=%b cnt=%0d need 0/3", out_ecc_fault, fault_cnt);
        else passed++;
        en = 1'b1;
        bypass = 1'b1;
        in_valid = 1'b1;
        in_data = rand_data() | 1;
        tick();
        in_valid = 1'b0;
        bypass = 1'b0;
        total++;
        if (out_ecc_fault !== 1'b0 || out_parity !== 9'h000 || fault_cnt !== 8'd3)
            $display("FAIL fault_bypass: got flt=%b par=%h cnt=%0d need 0/000/3",
                     out_ecc_fault, out_parity, fault_cnt);
        else passed++;
        send_zero(100);
        total++;
        if (fault_cnt !== 8'd103) $display("FAIL fault_cnt_mid: got %0d need 103", fault_cnt);
        else passed++;
        send_zero(200);
        total++;
        if (fault_cnt !== 8'hFF || fault_sticky !== 1'b1)
            $display("FAIL fault_saturate: got cnt=%0d sticky=%b need 255/1", fault_cnt, fault_sticky);
        else passed++;
    endtask

    task automatic test_fault_clr();
        fault_clr = 1'b1;
        in_valid  = 1'b1;
        in_data   = '0;
        tick();
        in_valid = 1'b0;
        total++;
        if (fault_cnt !== 8'd1 || fault_sticky !== 1'b1)
            $display("FAIL clr_with_fault: got cnt=%0d sticky=%b need 1/1", fault_cnt, fault_sticky);
        else passed++;
        tick();
        fault_clr = 1'b0;
        total++;
        if (fault_cnt !== 8'd0 || fault_sticky !== 1'b0)
            $display("FAIL clr_alone: got cnt=%0d sticky=%b need 0/0", fault_cnt, fault_sticky);
        else passed++;
        send_zero(1);
        tick();
        tick();
        total++;
        if (fault_cnt !== 8'd1 || fault_sticky !== 1'b1)
            $display("FAIL idle_hold: got cnt=%0d sticky=%b need 1/1", fault_cnt, fault_sticky);
        else passed++;
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        release dut.p1;
        en = 1'b1;
    endtask

    task automatic test_inject();
        logic [DW-1:0] d;
        logic [PW-1:0] full;
        logic [DW-1:0] m0;
        logic [DW-1:0] m1;
        m0 = '0;
        m0[B0] = 1'b1;
        m1 = m0;
        m1[B1] = 1'b1;
        in_data  = '0;
        in_valid = 1'b1;
        inj_sbit = 1'b1;
        tick();
        total++;
        full = ref_parity(out_data) ^ out_parity;
        if (out_data !== m0 || out_parity !== 9'h000 || full[7:0] === 8'h00 || full[8] !== 1'b1)
            $display("FAIL inj_single: got data_ok=%b par=%h syn=%h ovr=%b need data=1<<%0d par=000 syn!=0 ovr=1",
                     out_data === m0, out_parity, full[7:0], full[8], B0);
        else passed++;
        inj_dbit = 1'b1;
        tick();
        total++;
        full = ref_parity(out_data) ^ out_parity;
        if (out_data !== m1 || out_parity !== 9'h000 || full[7:0] === 8'h00 || full[8] !== 1'b0)
            $display("FAIL inj_double: got data_ok=%b par=%h syn=%h ovr=%b need bits %0d,%0d par=000 syn!=0 ovr=0",
                     out_data === m1, out_parity, full[7:0], full[8], B0, B1);
        else passed++;
        inj_sbit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d = rand_data();
            in_data = d;
            tick();
            total++;
            if (out_data !== (d ^ m1) || out_parity !== ref_parity(d) || out_ecc_fault !== 1'b0)
                $display("FAIL inj_random[%0d]: got par=%h flt=%b data_ok=%b need par=%h flt=0",
                         i, out_parity, out_ecc_fault, out_data === (d ^ m1), ref_parity(d));
            else passed++;
        end
        inj_dbit = 1'b0;
        in_valid = 1'b0;
        tick();
        total++;
        if (out_valid !== 1'b0) $display("FAIL inj_no_idle_beat: got valid=%b need 0", out_valid);
        else passed++;
    endtask

    task automatic test_async_reset();
        in_valid  = 1'b1;
        in_data   = rand_data();
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1)
            $display("FAIL async_reset: got valid=%b data_nz=%b ready=%b need 0/0/1",
                     out_valid, |out_data, in_ready);
        else passed++;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_first_beat();
        test_stream();
        test_back_to_back();
        test_fault();
        test_fault_clr();
        test_inject();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
